// File: rtl/pkg_memorymap.sv
// NPU bus memory map: region bounds decoded by npu_cmd_decoder.
package pkg_memorymap;

    localparam logic [31:0] NPU_IMEM_Start = 32'h1000_0000;
    localparam logic [31:0] NPU_IMEM_End   = 32'h1000_1000;
    localparam logic [31:0] NPU_WMEM_Start = 32'h1001_0000;
    localparam logic [31:0] NPU_WMEM_End   = 32'h1002_0000;
    localparam logic [31:0] NPU_BMEM_Start = 32'h1002_0000;
    localparam logic [31:0] NPU_BMEM_End   = 32'h1002_1000;
    localparam logic [31:0] NPU_OMEM_Start = 32'h1003_0000;
    localparam logic [31:0] NPU_OMEM_End   = 32'h1003_1000;
    localparam logic [31:0] NPU_PARA_Start = 32'h1004_0000;
    localparam logic [31:0] NPU_PARA_End   = 32'h1004_0100;
    localparam logic [31:0] NPU_OP_Start   = 32'h1005_0000;

endpackage

// File: rtl/npu_cmd_decoder.sv
// Decodes NPU bus accesses into op entries and queues them in a small FIFO
// whose head is presented on registered op_* outputs; unmatched accesses raise a sticky error.
module npu_cmd_decoder
    import pkg_memorymap::*;
#(
    parameter int unsigned DWidth     = 8,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               cen_i,
    input  logic                               wen_i,
    input  logic [ADDR_WIDTH-1:0]              addr_i,
    input  logic [DWidth-1:0]                  wdata_i,
    output logic                               req_ready_o,
    output logic                               op_valid_o,
    output logic [3:0]                         op_type_o,
    output logic [ADDR_WIDTH-1:0]              op_offset_o,
    output logic [DWidth-1:0]                  op_wdata_o,
    output logic                               op_wen_o,
    input  logic                               op_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o,
    output logic                               err_o,
    output logic [ADDR_WIDTH-1:0]              err_addr_o,
    input  logic                               err_clr_i
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [3:0]            op_type;
        logic [ADDR_WIDTH-1:0] offset;
        logic [DWidth-1:0]     wdata;
        logic                  wen;
    } entry_t;

    localparam logic [ADDR_WIDTH-1:0] ImemS = ADDR_WIDTH'(NPU_IMEM_Start);
    localparam logic [ADDR_WIDTH-1:0] ImemE = ADDR_WIDTH'(NPU_IMEM_End);
    localparam logic [ADDR_WIDTH-1:0] WmemS = ADDR_WIDTH'(NPU_WMEM_Start);
    localparam logic [ADDR_WIDTH-1:0] WmemE = ADDR_WIDTH'(NPU_WMEM_End);
    localparam logic [ADDR_WIDTH-1:0] BmemS = ADDR_WIDTH'(NPU_BMEM_Start);
    localparam logic [ADDR_WIDTH-1:0] BmemE = ADDR_WIDTH'(NPU_BMEM_End);
    localparam logic [ADDR_WIDTH-1:0] OmemS = ADDR_WIDTH'(NPU_OMEM_Start);
    localparam logic [ADDR_WIDTH-1:0] OmemE = ADDR_WIDTH'(NPU_OMEM_End);
    localparam logic [ADDR_WIDTH-1:0] ParaS = ADDR_WIDTH'(NPU_PARA_Start);
    localparam logic [ADDR_WIDTH-1:0] ParaE = ADDR_WIDTH'(NPU_PARA_End);
    localparam logic [ADDR_WIDTH-1:0] OpS   = ADDR_WIDTH'(NPU_OP_Start);
    localparam logic [ADDR_WIDTH-1:0] OpS4  = ADDR_WIDTH'(NPU_OP_Start + 32'd4);

    entry_t                mem_q [FIFO_DEPTH];
    entry_t                op_q, op_d;
    logic                  op_valid_q, op_valid_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

    logic                  matched;
    logic [3:0]            dec_type;
    logic [ADDR_WIDTH-1:0] dec_off;
    logic                  accept, push, pop;
    entry_t                push_entry;

    // First-match decode; an unknown address leaves every condition untaken.
    always_comb begin
        matched  = 1'b0;
        dec_type = 4'b0111;
        dec_off  = '0;
        if (addr_i >= ImemS && addr_i < ImemE && wen_i) begin
            matched = 1'b1; dec_type = 4'b1000; dec_off = addr_i - ImemS;
        end else if (addr_i >= WmemS && addr_i < WmemE && wen_i) begin
            matched = 1'b1; dec_type = 4'b1001; dec_off = addr_i - WmemS;
        end else if (addr_i >= BmemS && addr_i < BmemE && wen_i) begin
            matched = 1'b1; dec_type = 4'b1010; dec_off = addr_i - BmemS;
        end else if (addr_i >= OmemS && addr_i < OmemE) begin
            matched = 1'b1; dec_type = 4'b1011; dec_off = addr_i - OmemS;
        end else if (addr_i >= ParaS && addr_i < ParaE) begin
            matched = 1'b1; dec_type = 4'b1100; dec_off = addr_i - ParaS;
        end else if (addr_i == OpS && wen_i) begin
            matched = 1'b1; dec_type = 4'b1111;
        end else if (addr_i == OpS4 && wen_i) begin
            matched = 1'b1; dec_type = 4'b0001;
        end
    end

    assign req_ready_o = (count_q < CntW'(FIFO_DEPTH));
    assign accept      = cen_i && req_ready_o;
    assign push        = accept && matched;
    assign pop         = op_valid_q && op_ready_i;
    assign push_entry  = '{op_type: dec_type, offset: dec_off, wdata: wdata_i, wen: wen_i};

    // Next-state for pointers, occupancy, head register and error flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        op_d       = op_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;

        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (push && !pop)      count_d = count_q + CntW'(1);
        else if (!push && pop) count_d = count_q - CntW'(1);

        // Head register follows the new head; a push into an emptying queue bypasses memory.
        if (count_d != '0) begin
            if (push && wr_ptr_q == rd_ptr_d) op_d = push_entry;
            else                              op_d = mem_q[rd_ptr_d];
        end
        op_valid_d = (count_d != '0);

        if (accept && !matched) begin
            err_d      = 1'b1;
            err_addr_d = addr_i;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '{op_type: 4'b0111, default: '0};
            op_q       <= '{op_type: 4'b0111, default: '0};
            op_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= push_entry;
            op_q       <= op_d;
            op_valid_q <= op_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign op_valid_o  = op_valid_q;
    assign op_type_o   = op_q.op_type;
    assign op_offset_o = op_q.offset;
    assign op_wdata_o  = op_q.wdata;
    assign op_wen_o    = op_q.wen;
    assign count_o     = count_q;
    assign err_o       = err_q;
    assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_npu_cmd_decoder.sv
// Directed bench for npu_cmd_decoder: decode table, FIFO ordering/full/wrap, errors and reset.
module tb_npu_cmd_decoder;
    import pkg_memorymap::*;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cen, wen, op_ready, err_clr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          req_ready, op_valid, op_wen, err;
    logic [3:0]    op_type;
    logic [AW-1:0] op_offset, err_addr;
    logic [DW-1:0] op_wdata;
    logic [2:0]    count;

    int checks = 0;
    int errors = 0;

    npu_cmd_decoder #(.DWidth(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .clk_i(clk), .rst_i(rst), .cen_i(cen), .wen_i(wen), .addr_i(addr),
        .wdata_i(wdata), .req_ready_o(req_ready), .op_valid_o(op_valid),
        .op_type_o(op_type), .op_offset_o(op_offset), .op_wdata_o(op_wdata),
        .op_wen_o(op_wen), .op_ready_i(op_ready), .count_o(count), .err_o(err),
        .err_addr_o(err_addr), .err_clr_i(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cen = 1'b1; wen = w; addr = a; wdata = d;
    endtask

    task automatic idle();
        cen = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
    endtask

    initial begin
        rst = 1'b1; op_ready = 1'b0; err_clr = 1'b0;
        bus(1'b1, NPU_IMEM_Start, 8'h11);
        tick(); tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(op_valid), 64'd0);
        chk("rst_type", 64'(op_type), 64'h7);
        chk("rst_offset", 64'(op_offset), 64'd0);
        chk("rst_wdata", 64'(op_wdata), 64'd0);
        chk("rst_wen", 64'(op_wen), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_erraddr", 64'(err_addr), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd1);
        idle();
        rst = 1'b0;
        tick();

        // single IMEM write, one-cycle latency, popped next edge
        op_ready = 1'b1;
        bus(1'b1, NPU_IMEM_Start + 32'd5, 8'hA5);
        tick(); idle();
        chk("imem_valid", 64'(op_valid), 64'd1);
        chk("imem_type", 64'(op_type), 64'h8);
        chk("imem_offset", 64'(op_offset), 64'd5);
        chk("imem_wdata", 64'(op_wdata), 64'hA5);
        chk("imem_wen", 64'(op_wen), 64'd1);
        chk("imem_count", 64'(count), 64'd1);
        tick();
        chk("imem_popped_valid", 64'(op_valid), 64'd0);
        chk("imem_popped_count", 64'(count), 64'd0);

        // fill to full, fifth rejected without error
        op_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus(1'b1, NPU_WMEM_Start + 32'(i), 8'(8'h40 + i));
            chk("fill_ready", 64'(req_ready), (i < 4) ? 64'd1 : 64'd0);
            tick();
        end
        idle();
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(req_ready), 64'd0);
        chk("full_noerr", 64'(err), 64'd0);
        tick();
        chk("hold_offset", 64'(op_offset), 64'd0);
        chk("hold_type", 64'(op_type), 64'h9);
        op_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_offset", 64'(op_offset), 64'(i));
            chk("drain_wdata", 64'(op_wdata), 64'(8'h40 + i));
            tick();
        end
        op_ready = 1'b0;
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_valid", 64'(op_valid), 64'd0);

        // read of BMEM is an error, clear keeps address
        bus(1'b0, NPU_BMEM_Start, 8'h00);
        tick(); idle();
        chk("bmem_rd_count", 64'(count), 64'd0);
        chk("bmem_rd_err", 64'(err), 64'd1);
        chk("bmem_rd_addr", 64'(err_addr), 64'(NPU_BMEM_Start));
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("clr_err", 64'(err), 64'd0);
        chk("clr_addr", 64'(err_addr), 64'(NPU_BMEM_Start));
        // clear and new error on same edge: set wins
        err_clr = 1'b1;
        bus(1'b0, NPU_IMEM_Start + 32'd8, 8'h00);
        tick(); idle(); err_clr = 1'b0;
        chk("setwins_err", 64'(err), 64'd1);
        chk("setwins_addr", 64'(err_addr), 64'(NPU_IMEM_Start + 32'd8));
        // PARA end is exclusive
        bus(1'b0, NPU_PARA_End, 8'h00);
        tick(); idle();
        chk("para_end_addr", 64'(err_addr), 64'(NPU_PARA_End));
        chk("para_end_count", 64'(count), 64'd0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;

        // OP commands back-to-back, PARA read, OMEM last-byte read
        bus(1'b1, NPU_OP_Start, 8'h01); tick();
        bus(1'b1, NPU_OP_Start + 32'd4, 8'h02); tick();
        bus(1'b0, NPU_PARA_Start, 8'h03); tick();
        bus(1'b0, NPU_OMEM_End - 32'd1, 8'h04); tick();
        idle();
        chk("op_count", 64'(count), 64'd4);
        chk("op_err", 64'(err), 64'd0);
        op_ready = 1'b1;
        chk("op_start_type", 64'(op_type), 64'hF);
        chk("op_start_off", 64'(op_offset), 64'd0);
        tick();
        chk("op_start4_type", 64'(op_type), 64'h1);
        chk("op_start4_off", 64'(op_offset), 64'd0);
        tick();
        chk("para_type", 64'(op_type), 64'hC);
        chk("para_wen", 64'(op_wen), 64'd0);
        chk("para_off", 64'(op_offset), 64'd0);
        tick();
        chk("omem_type", 64'(op_type), 64'hB);
        chk("omem_off", 64'(op_offset), 64'hFFF);
        tick();
        op_ready = 1'b0;
        chk("op_drained", 64'(count), 64'd0);

        // two queued, six simultaneous push+pop cycles
        bus(1'b1, NPU_OMEM_Start, 8'h00); tick();
        bus(1'b1, NPU_OMEM_Start + 32'd1, 8'h01); tick();
        op_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus(1'b1, NPU_OMEM_Start + 32'(i + 2), 8'(i + 2));
            chk("pp_count", 64'(count), 64'd2);
            chk("pp_offset", 64'(op_offset), 64'(i));
            tick();
        end
        idle();
        chk("pp_end_count", 64'(count), 64'd2);
        chk("pp_end_offset", 64'(op_offset), 64'd6);
        tick();
        chk("pp_last_offset", 64'(op_offset), 64'd7);
        chk("pp_last_wdata", 64'(op_wdata), 64'd7);
        tick();
        op_ready = 1'b0;
        chk("pp_empty", 64'(op_valid), 64'd0);

        // reset mid-stream with three entries and a pending error
        bus(1'b0, NPU_WMEM_Start, 8'h00); tick();
        for (int i = 0; i < 3; i++) begin
            bus(1'b1, NPU_BMEM_Start + 32'(i), 8'(i)); tick();
        end
        idle();
        chk("pre_rst_count", 64'(count), 64'd3);
        chk("pre_rst_err", 64'(err), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 64'(op_valid), 64'd0);
        chk("async_count", 64'(count), 64'd0);
        chk("async_err", 64'(err), 64'd0);
        chk("async_type", 64'(op_type), 64'h7);
        chk("async_ready", 64'(req_ready), 64'd1);
        tick();
        rst = 1'b0;
        bus(1'b1, NPU_IMEM_Start + 32'd3, 8'h5A); tick(); idle();
        chk("resume_valid", 64'(op_valid), 64'd1);
        chk("resume_offset", 64'(op_offset), 64'd3);
        chk("resume_count", 64'(count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/npu_cmd_decoder.md
NPU_CMD_DECODER -- requirements
Module: npu_cmd_decoder

Interface
REQ-001 SHALL have parameter DWidth, default 8, write data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, bus address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, decoded-op queue depth (power of two, >=2).
REQ-004 SHALL take region bounds NPU_{IMEM,WMEM,BMEM,OMEM,PARA}_{Start,End} and NPU_OP_Start from pkg_memorymap.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk_i  input  1  clock, all state on rising edge.
REQ-007 rst_i  input  1  asynchronous active-high reset.
REQ-008 cen_i  input  1  bus access enable.
REQ-009 wen_i  input  1  1 = write, 0 = read.
REQ-010 addr_i  input  ADDR_WIDTH  access address.
REQ-011 wdata_i  input  DWidth  write data.
REQ-012 req_ready_o  output  1  decoder can accept an access.
REQ-013 op_valid_o  output  1  head of op queue is valid.
REQ-014 op_type_o  output  4  decoded op code of head entry.
REQ-015 op_offset_o  output  ADDR_WIDTH  addr_i minus matched region start (0 for OP commands).
REQ-016 op_wdata_o  output  DWidth  captured wdata_i of head entry.
REQ-017 op_wen_o  output  1  captured wen_i of head entry.
REQ-018 op_ready_i  input  1  consumer pops head entry.
REQ-019 count_o  output  $clog2(FIFO_DEPTH+1)  number of queued entries.
REQ-020 err_o  output  1  sticky decode-error flag.
REQ-021 err_addr_o  output  ADDR_WIDTH  address of most recent decode error.
REQ-022 err_clr_i  input  1  clears err_o.

Function
REQ-023 Accept occurs on a rising edge where cen_i=1 and req_ready_o=1; no other cycle changes queue or error state from the bus.
REQ-024 Decode, first match wins: IMEM & wen=1 -> 4'b1000; WMEM & wen=1 -> 4'b1001; BMEM & wen=1 -> 4'b1010; OMEM (any wen) -> 4'b1011; PARA [Start,End) (any wen) -> 4'b1100; addr==NPU_OP_Start & wen=1 -> 4'b1111; addr==NPU_OP_Start+4 & wen=1 -> 4'b0001.
REQ-025 Region match SHALL be Start <= addr_i < End, unsigned compare at ADDR_WIDTH.
REQ-026 Accepted matched access SHALL push {op_type, offset, wdata, wen} into the queue.
REQ-027 Accepted unmatched access (incl. reads of IMEM/WMEM/BMEM/OP) SHALL not push, SHALL set err_o=1 and load err_addr_o with addr_i.
REQ-028 addr_i containing X/Z SHALL be treated as unmatched in simulation; op code 4'b0111 never enters the queue.
REQ-029 req_ready_o SHALL be combinational: 1 when count_o < FIFO_DEPTH, else 0.
REQ-030 Latency: entry accepted at edge k SHALL appear on op_* with op_valid_o=1 after edge k when queue was empty (one cycle).
REQ-031 Pop occurs on an edge with op_valid_o=1 and op_ready_i=1; op_ready_i with empty queue SHALL be ignored.
REQ-032 Push and pop in the same edge: count_o unchanged, order preserved (FIFO).
REQ-033 Full queue: req_ready_o=0; a pop that edge does not admit a push in the same edge.
REQ-034 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-035 op_* outputs SHALL be held stable while op_valid_o=1 and op_ready_i=0.
REQ-036 err_clr_i and a new error on the same edge: set wins, err_addr_o updated.
REQ-037 err_addr_o SHALL hold its value when err_clr_i clears err_o.

Reset
REQ-038 rst_i=1 SHALL immediately force count_o=0, op_valid_o=0, op_type_o=4'b0111, op_offset_o=0, op_wdata_o=0, op_wen_o=0, err_o=0, err_addr_o=0, pointers=0, discarding queued entries, including mid-transfer.
REQ-039 req_ready_o SHALL be 1 while rst_i=1 is held, but no access is accepted until the first edge after rst_i falls.

Verification
REQ-040 Write IMEM_Start+5, wdata=0xA5, op_ready_i=1 -> next cycle op_valid_o=1, op_type_o=4'b1000, op_offset_o=5, op_wdata_o=0xA5, popped next edge.
REQ-041 op_ready_i=0, five writes to WMEM_Start..+4 -> count_o reaches 4, req_ready_o=0, fifth access not accepted; then four pops yield offsets 0,1,2,3 in order.
REQ-042 Read of BMEM_Start -> no push, err_o=1, err_addr_o=BMEM_Start; err_clr_i pulse -> err_o=0, err_addr_o unchanged.
REQ-043 Write NPU_OP_Start then NPU_OP_Start+4 back-to-back -> op_type_o 4'b1111 then 4'b0001, offsets 0; read of PARA_Start -> 4'b1100, op_wen_o=0.
REQ-044 Queue holding 2 entries, simultaneous push and pop for 6 cycles -> count_o stays 2, pointers wrap, order preserved.
REQ-045 rst_i asserted mid-stream with 3 entries queued -> same cycle op_valid_o=0, count_o=0, err_o=0; normal accept resumes after release.
